// File: rtl/tnoc_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tnoc_arbiter_pkg
//  Description : Shared state encoding and round-robin selector for the
//                tnoc packet arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package tnoc_arbiter_pkg;

    localparam int c_MAX_REQUESTS = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } tnoc_wrr_state_e;

    // One-hot pick of the first set request at or after pointer, wrapping
    // modulo requests. Vectors are sized to the largest supported arbiter.
    function automatic logic [c_MAX_REQUESTS-1:0] rr_select(
        input logic [c_MAX_REQUESTS-1:0] request,
        input int unsigned               pointer,
        input int unsigned               requests
    );
        logic [c_MAX_REQUESTS-1:0] grant;
        logic                      found;
        int unsigned               idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < c_MAX_REQUESTS; k++) begin
            idx = pointer + k;
            if (idx >= requests) begin
                idx = idx - requests;
            end
            if (!found && (k < requests) && (idx < requests) && request[idx[4:0]]) begin
                grant[idx[4:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tnoc_wrr_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tnoc_wrr_credit_counter
//  Description : Per-requester credit counter: loads max(weight,1) on reset
//                and reload, decrements on grant, flags exhaustion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tnoc_wrr_credit_counter #(
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WEIGHT_WIDTH-1:0] i_weight,
    input  logic                    i_reload,
    input  logic                    i_decrement,
    output logic                    o_zero
);

    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic [WEIGHT_WIDTH-1:0] w_load_value;
    logic [WEIGHT_WIDTH-1:0] w_base;

    always_comb begin
        w_load_value = (i_weight == '0) ? WEIGHT_WIDTH'(1) : i_weight;
        // A reload and a grant in the same cycle charge the fresh credit.
        w_base       = i_reload ? w_load_value : r_credit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= w_load_value;
        end else if (i_decrement) begin
            r_credit <= w_base - WEIGHT_WIDTH'(1);
        end else if (i_reload) begin
            r_credit <= w_base;
        end
    end

    assign o_zero = (r_credit == '0);

endmodule
`default_nettype wire

// File: rtl/tnoc_packet_wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tnoc_packet_wrr_arbiter
//  Description : Packet-level weighted round-robin arbiter; grant is locked
//                from head to tail flit. Optional per-requester grant
//                counters with TNOC_PACKET_WRR_ARBITER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tnoc_packet_wrr_arbiter
    import tnoc_arbiter_pkg::*;
#(
    parameter int REQUESTS     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTS-1:0]              i_request,
    input  logic [REQUESTS-1:0]              i_free,
    input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
    output logic [REQUESTS-1:0]              o_grant,
    output logic                             o_busy
`ifdef TNOC_PACKET_WRR_ARBITER_STATS_EN
    ,
    output logic [REQUESTS*COUNT_WIDTH-1:0]  o_grant_count
`endif
);

    localparam int c_PTR_WIDTH = $clog2(REQUESTS);

    tnoc_wrr_state_e           r_state;
    logic [c_PTR_WIDTH-1:0]    r_pointer;
    logic [c_PTR_WIDTH-1:0]    r_owner;
    logic [REQUESTS-1:0]       r_grant;

    logic [REQUESTS-1:0]       w_credit_zero;
    logic [REQUESTS-1:0]       w_eligible;
    logic [REQUESTS-1:0]       w_winner;
    logic                      w_reload;
    logic [c_MAX_REQUESTS-1:0] w_select;
    logic [c_PTR_WIDTH-1:0]    w_winner_idx;

    function automatic logic [c_PTR_WIDTH-1:0] ptr_next(input logic [c_PTR_WIDTH-1:0] idx);
        return (idx == c_PTR_WIDTH'(REQUESTS - 1)) ? '0 : idx + c_PTR_WIDTH'(1);
    endfunction

    if (REQUESTS < 2) begin : g_requests_invalid
    end
    if (COUNT_WIDTH < 1) begin : g_count_width_invalid
    end

    always_comb begin
        w_eligible = i_request & ~w_credit_zero;
        w_reload   = 1'b0;
        // Everyone still asking is out of credit: start a new round now.
        if ((r_state == IDLE) && !rst && (w_eligible == '0) && (i_request != '0)) begin
            w_reload   = 1'b1;
            w_eligible = i_request;
        end
        w_select = rr_select(c_MAX_REQUESTS'(w_eligible), 32'(r_pointer), REQUESTS);
        w_winner = ((r_state == IDLE) && !rst) ? w_select[REQUESTS-1:0] : '0;
        w_winner_idx = '0;
        for (int k = 0; k < c_MAX_REQUESTS; k++) begin
            if (w_select[k]) begin
                w_winner_idx = c_PTR_WIDTH'(k);
            end
        end
    end

    for (genvar j = 0; j < REQUESTS; j++) begin : g_credit
        tnoc_wrr_credit_counter #(
            .WEIGHT_WIDTH (WEIGHT_WIDTH)
        ) u_credit (
            .clk         (clk),
            .rst         (rst),
            .i_weight    (i_weight[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .i_reload    (w_reload),
            .i_decrement (w_winner[j]),
            .o_zero      (w_credit_zero[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pointer <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_winner != '0) begin
                        if ((i_free & w_winner) != '0) begin
                            r_pointer <= ptr_next(w_winner_idx);
                        end else begin
                            r_state <= LOCKED;
                            r_grant <= w_winner;
                            r_owner <= w_winner_idx;
                        end
                    end
                end
                LOCKED: begin
                    if ((i_free & r_grant) != '0) begin
                        r_state   <= IDLE;
                        r_grant   <= '0;
                        r_pointer <= ptr_next(r_owner);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_grant = rst ? '0 : ((r_state == LOCKED) ? r_grant : w_winner);
    assign o_busy  = (r_state == LOCKED);

`ifdef TNOC_PACKET_WRR_ARBITER_STATS_EN
    for (genvar j = 0; j < REQUESTS; j++) begin : g_stats
        logic [COUNT_WIDTH-1:0] r_count;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_count <= '0;
            end else if (w_winner[j] && (r_count != '1)) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
        assign o_grant_count[j*COUNT_WIDTH +: COUNT_WIDTH] = r_count;
    end
`endif

endmodule
`default_nettype wire
